dm_byteen_ws: RTL and testbench
===============================

// Module: dm_byteen_ws
// PURPOSE
// - Synthesisable data memory for the pipelined MIPS core: 32-bit words, per-byte write enables, programmable wait states.
// - Replaces the bench-side data array; sits between the MEM stage and the bench; core stalls on req_ready/rsp_valid.
// - Emits a one-cycle write-trace record (pc, word address, merged word) per committed store for log comparison.
// PARAMETERS
// - DEPTH_WORDS    4096      words of storage; power of two, >=2
// - BASE_ADDR      32'h0     byte address of word 0
// - WAIT_CYCLES    0         extra cycles between accept and access; 0..15
// - CLEAR_ON_RESET 1         1: zero every word after reset before first accept
// PORTS
// - clk          in   1   clock, all state on rising edge
// - reset        in   1   asynchronous, active-high
// - req_valid    in   1   request present
// - req_ready    out  1   block can accept; transfer when req_valid & req_ready
// - req_addr     in   32  byte address; bits [1:0] ignored
// - req_be       in   4   byte enables, bit i -> bits [8i+7:8i]; 4'b0000 = read
// - req_wdata    in   32  store data, lane-aligned
// - req_pc       in   32  pc of the issuing instruction, for trace only
// - rsp_valid    out  1   one-cycle pulse: access complete
// - rsp_rdata    out  32  read word (0 for writes and errors)
// - rsp_err      out  1   address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
// - wr_log_valid out  1   one-cycle pulse: a word was written
// - wr_log_pc    out  32  req_pc of that store
// - wr_log_addr  out  32  word-aligned byte address ({addr[31:2],2'b00})
// - wr_log_data  out  32  full word after the merge
// BEHAVIOUR
// - Reset (async): state CLEAR if CLEAR_ON_RESET else IDLE; req_ready, rsp_valid, rsp_err, wr_log_valid = 0;
//   rsp_rdata, wr_log_* = 0; wait counter and clear index = 0. Array not reset directly.
// - FSM CLEAR: writes 0 to word idx each cycle, idx 0..DEPTH_WORDS-1, then IDLE; req_ready=0; no trace.
// - IDLE: req_ready=1. On transfer latch addr/be/wdata/pc; WAIT_CYCLES=0 -> access at that edge, go RESP;
//   else load counter=WAIT_CYCLES-1, go WAIT.
// - WAIT: req_ready=0; counter decrements; access performed at the edge where counter==0, then RESP.
// - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE. No backpressure on rsp.
// - Latency: accept edge N -> rsp_valid high in cycle after edge N+WAIT_CYCLES. Throughput 1 per WAIT_CYCLES+2 cycles.
// - Access, in-range read: rsp_rdata = array[word index]; rsp_err=0.
// - Access, in-range write (be!=0): new = old word with enabled lanes replaced; array updated;
//   wr_log_valid=1 with pc/addr/new during the RESP cycle; rsp_rdata=0.
// - Out of range (unsigned addr-BASE_ADDR >= 4*DEPTH_WORDS): no array change, no trace, rsp_rdata=0, rsp_err=1.
// - Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits only after range check.
// - Misaligned addr: silently word-aligned; be alone selects lanes.
// - Reset mid-WAIT or mid-CLEAR: request dropped, no write committed, no rsp; CLEAR restarts at idx 0.
// - req_* inputs ignored whenever req_ready=0; latched values used for the access.
// STRUCTURE
// - Shared header dm_defs.vh: FSM state codes (CLEAR, IDLE, WAIT, RESP), BE_READ=4'b0000, lane width 8.
// - Sub-module be_merge: combinational old/new/be -> merged word; reused by future cache fill path.
// - Top holds FSM, wait counter, clear index, request latch, array, response and trace registers.
// TESTING
// - Reset, CLEAR_ON_RESET=1, DEPTH_WORDS=16: req_ready low 16 cycles then high; read 0x3c -> rdata 0, err 0.
// - WAIT_CYCLES=0: sw 0x12345678 @0x8 pc 0x3004 -> trace {3004,00000008,12345678}; lw 0x8 -> 12345678 two cycles later.
// - Byte lanes: word 0x4=0xAABBCCDD, be=4'b0010 wdata 0x0000EE00 @0x6 -> trace addr 0x4 data AABBEEDD; sh be=1100 0xFFFF0000 -> FFFFEEDD.
// - WAIT_CYCLES=3: lw accepted edge N -> rsp_valid only in cycle after N+3; req_ready low through WAIT and RESP.
// - Range: BASE_ADDR=0x1000, DEPTH_WORDS=16: sw @0x1040 -> rsp_err=1, no trace, word 0 unchanged; lw @0x0FFC -> err=1, rdata 0.
// - Reset asserted during WAIT of a store to 0x10: no trace, rsp_valid stays 0, post-CLEAR read of 0x10 returns 0.

Source files
------------

// File: rtl/dm_byteen_ws_pkg.sv
// Shared definitions for the byte-enabled, wait-stated data memory:
// FSM state codes, lane geometry and the read-request encoding.
package dm_byteen_ws_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int WORD_W    = LANE_W * NUM_LANES;

    localparam logic [NUM_LANES-1:0] BE_READ = 4'b0000;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dm_state_e;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dm_byteen_ws_be_merge.sv
// Combinational lane merge: each enabled byte lane takes the new data,
// the rest keep the old word.
module be_merge
    import dm_byteen_ws_pkg::*;
(
    input  logic [WORD_W-1:0]    old_word_i,
    input  logic [WORD_W-1:0]    new_word_i,
    input  logic [NUM_LANES-1:0] be_i,
    output logic [WORD_W-1:0]    merged_o
);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign merged_o[gi*LANE_W +: LANE_W] = be_i[gi] ? new_word_i[gi*LANE_W +: LANE_W]
                                                             : old_word_i[gi*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/dm_byteen_ws.sv
// Data memory for the pipelined core: one request at a time, optional wait
// states, per-byte writes, and a one-cycle trace record for every committed store.
module dm_byteen_ws
    import dm_byteen_ws_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned WAIT_CYCLES    = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wr_log_valid,
    output logic [31:0] wr_log_pc,
    output logic [31:0] wr_log_addr,
    output logic [31:0] wr_log_data
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dm_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;

    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        log_valid_q;
    logic [31:0] log_pc_q, log_addr_q, log_data_q;

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          acc_fire;
    logic [31:0]   acc_addr, acc_wdata, acc_pc;
    logic [3:0]    acc_be;
    logic [31:0]   offset;
    logic          in_range;
    logic          is_write;
    logic [AW-1:0] acc_idx;
    logic [31:0]   old_word, merged_word;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    assign accept = ready_q && req_valid;

    // With no wait states the access happens on the accept edge, so it must
    // use the live request rather than the latch being loaded at that edge.
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_pc    = (state_q == ST_IDLE) ? req_pc    : pc_q;

    assign acc_fire = (accept && (WAIT_CYCLES == 0)) || ((state_q == ST_WAIT) && (cnt_q == 4'd0));

    assign offset   = acc_addr - BASE_ADDR;
    assign in_range = ({1'b0, offset} < SPAN);
    assign acc_idx  = AW'(offset >> 2);
    assign is_write = (acc_be != BE_READ);
    assign old_word = mem[acc_idx];

    be_merge u_merge (
        .old_word_i (old_word),
        .new_word_i (acc_wdata),
        .be_i       (acc_be),
        .merged_o   (merged_word)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = acc_idx;
        mem_wdata = merged_word;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = '0;
        end else if (acc_fire && in_range && is_write) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_idx_d = clr_idx_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        pc_d      = pc_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    clr_idx_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q       <= '0;
            clr_idx_q   <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            log_valid_q <= 1'b0;
            log_pc_q    <= '0;
            log_addr_q  <= '0;
            log_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_idx_q   <= clr_idx_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= acc_fire;
            log_valid_q <= acc_fire && in_range && is_write;
            if (acc_fire) begin
                rsp_rdata_q <= (in_range && !is_write) ? old_word : 32'h0;
                rsp_err_q   <= !in_range;
            end
            if (acc_fire && in_range && is_write) begin
                log_pc_q   <= acc_pc;
                log_addr_q <= word_align(acc_addr);
                log_data_q <= merged_word;
            end
        end
    end

    assign req_ready    = ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign wr_log_valid = log_valid_q;
    assign wr_log_pc    = log_pc_q;
    assign wr_log_addr  = log_addr_q;
    assign wr_log_data  = log_data_q;

endmodule

// File: tb/tb_dm_byteen_ws.sv
// Scoreboard bench for dm_byteen_ws: three instances (no wait states at base 0,
// three wait states at base 0, no wait states at base 0x1000), all 16 words deep.
module tb_dm_byteen_ws;

    localparam int NI = 3;

    logic        clk;
    logic        reset;
    logic        req_valid    [NI];
    logic        req_ready    [NI];
    logic [31:0] req_addr     [NI];
    logic [3:0]  req_be       [NI];
    logic [31:0] req_wdata    [NI];
    logic [31:0] req_pc       [NI];
    logic        rsp_valid    [NI];
    logic [31:0] rsp_rdata    [NI];
    logic        rsp_err      [NI];
    logic        wr_log_valid [NI];
    logic [31:0] wr_log_pc    [NI];
    logic [31:0] wr_log_addr  [NI];
    logic [31:0] wr_log_data  [NI];

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            dm_byteen_ws #(
                .DEPTH_WORDS    (16),
                .BASE_ADDR      ((gi == 2) ? 32'h1000 : 32'h0),
                .WAIT_CYCLES    ((gi == 1) ? 3 : 0),
                .CLEAR_ON_RESET (1)
            ) u_dut (
                .clk          (clk),
                .reset        (reset),
                .req_valid    (req_valid[gi]),
                .req_ready    (req_ready[gi]),
                .req_addr     (req_addr[gi]),
                .req_be       (req_be[gi]),
                .req_wdata    (req_wdata[gi]),
                .req_pc       (req_pc[gi]),
                .rsp_valid    (rsp_valid[gi]),
                .rsp_rdata    (rsp_rdata[gi]),
                .rsp_err      (rsp_err[gi]),
                .wr_log_valid (wr_log_valid[gi]),
                .wr_log_pc    (wr_log_pc[gi]),
                .wr_log_addr  (wr_log_addr[gi]),
                .wr_log_data  (wr_log_data[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic        log;
        logic [31:0] lpc;
        logic [31:0] laddr;
        logic [31:0] ldata;
    } exp_t;

    exp_t sb[$];
    int   errors;
    int   checks;
    int   ncyc;
    int   acc_at  [NI];
    bit   pending [NI];

    function automatic int wait_of(input int i);
        return (i == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < NI; i++) begin
                if (reset) begin
                    pending[i] = 1'b0;
                end else begin
                    if (rsp_valid[i]) begin
                        if (sb.size() == 0 || sb[0].inst != i) begin
                            checks++;
                            errors++;
                            $display("FAIL stray_rsp inst%0d: got rsp_valid=1 required no response", i);
                        end else begin
                            e = sb.pop_front();
                            chk({e.name, " rdata"}, rsp_rdata[i], e.rdata);
                            chk({e.name, " err"}, 32'(rsp_err[i]), 32'(e.err));
                            chk({e.name, " log_valid"}, 32'(wr_log_valid[i]), 32'(e.log));
                            chk({e.name, " latency"}, 32'(ncyc - acc_at[i]), 32'(wait_of(i) + 1));
                            chk({e.name, " ready_in_resp"}, 32'(req_ready[i]), 32'd0);
                            if (e.log) begin
                                chk({e.name, " log_pc"}, wr_log_pc[i], e.lpc);
                                chk({e.name, " log_addr"}, wr_log_addr[i], e.laddr);
                                chk({e.name, " log_data"}, wr_log_data[i], e.ldata);
                            end
                        end
                        pending[i] = 1'b0;
                    end else if (wr_log_valid[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_log inst%0d: got wr_log_valid=1 without rsp_valid", i);
                    end
                    if (req_valid[i] && req_ready[i]) begin
                        acc_at[i]  = ncyc;
                        pending[i] = 1'b1;
                    end else if (pending[i] && req_ready[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL ready_busy inst%0d: got req_ready=1 while request in flight", i);
                    end
                end
            end
        end
    endtask

    // Called at posedge+2; returns at posedge+2 after the accept edge.
    task automatic issue(input int inst, input string name, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] pc,
                         input logic [31:0] exp_rdata, input logic exp_err, input logic exp_log,
                         input logic [31:0] exp_ldata, input bit push);
        exp_t e;
        int   n;
        n = 0;
        while (!req_ready[inst] && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!req_ready[inst]) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout: got req_ready=0 required 1 within 100 cycles", name);
            return;
        end
        if (push) begin
            e.inst  = inst;
            e.name  = name;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.log   = exp_log;
            e.lpc   = pc;
            e.laddr = {addr[31:2], 2'b00};
            e.ldata = exp_ldata;
            sb.push_back(e);
        end
        req_valid[inst] = 1'b1;
        req_addr[inst]  = addr;
        req_be[inst]    = be;
        req_wdata[inst] = wdata;
        req_pc[inst]    = pc;
        @(posedge clk);
        #2;
        req_valid[inst] = 1'b0;
        req_addr[inst]  = 32'hFFFF_FFF0;
        req_wdata[inst] = 32'hBAD0_BAD0;
        if (push) begin
            n = 0;
            while (sb.size() != 0 && n < 50) begin
                @(posedge clk);
                #2;
                n++;
            end
            if (sb.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL %s rsp_timeout: got no rsp_valid required one within 50 cycles", name);
                sb.delete();
            end
        end
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!req_ready[0] && n < 100);
        chk({name, " clear_cycles"}, 32'(n), 32'd16);
        for (int i = 1; i < NI; i++) begin
            chk($sformatf("%s ready_inst%0d", name, i), 32'(req_ready[i]), 32'd1);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ncyc   = 0;
        reset  = 1'b1;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            req_be[i]    = '0;
            req_wdata[i] = '0;
            req_pc[i]    = '0;
            acc_at[i]    = 0;
            pending[i]   = 1'b0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset ready_inst%0d", i), 32'(req_ready[i]), 32'd0);
            chk($sformatf("reset rsp_valid_inst%0d", i), 32'(rsp_valid[i]), 32'd0);
            chk($sformatf("reset log_valid_inst%0d", i), 32'(wr_log_valid[i]), 32'd0);
            chk($sformatf("reset rdata_inst%0d", i), rsp_rdata[i], 32'd0);
            chk($sformatf("reset log_data_inst%0d", i), wr_log_data[i], 32'd0);
        end
        reset = 1'b0;
        wait_clear("init");

        // No wait states, base 0
        issue(0, "lw_3c",     32'h3c, 4'b0000, 32'h0,        32'h0,    32'h0,        1'b0, 1'b0, 32'h0,        1'b1);
        issue(0, "sw_8",      32'h08, 4'b1111, 32'h12345678, 32'h3004, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1);
        issue(0, "lw_8",      32'h08, 4'b0000, 32'h0,        32'h3008, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b1);
        issue(0, "sw_4",      32'h04, 4'b1111, 32'hAABBCCDD, 32'h300C, 32'h0,        1'b0, 1'b1, 32'hAABBCCDD, 1'b1);
        issue(0, "sb_6",      32'h06, 4'b0010, 32'h0000EE00, 32'h3010, 32'h0,        1'b0, 1'b1, 32'hAABBEEDD, 1'b1);
        issue(0, "sh_6",      32'h06, 4'b1100, 32'hFFFF0000, 32'h3014, 32'h0,        1'b0, 1'b1, 32'hFFFFEEDD, 1'b1);
        issue(0, "lw_4",      32'h04, 4'b0000, 32'h0,        32'h3018, 32'hFFFFEEDD, 1'b0, 1'b0, 32'h0,        1'b1);
        issue(0, "lw_5_mis",  32'h05, 4'b0000, 32'h0,        32'h301C, 32'hFFFFEEDD, 1'b0, 1'b0, 32'h0,        1'b1);

        // Three wait states
        issue(1, "w3_lw_8",   32'h08, 4'b0000, 32'h0,        32'h4000, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1);
        issue(1, "w3_sw_20",  32'h20, 4'b1111, 32'hCAFEF00D, 32'h4004, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
        issue(1, "w3_lw_20",  32'h20, 4'b0000, 32'h0,        32'h4008, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        1'b1);

        // Range checks at base 0x1000
        issue(2, "rg_sw_1000", 32'h1000, 4'b1111, 32'h11111111, 32'h5000, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b1);
        issue(2, "rg_sw_1040", 32'h1040, 4'b1111, 32'h22222222, 32'h5004, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1);
        issue(2, "rg_lw_1000", 32'h1000, 4'b0000, 32'h0,        32'h5008, 32'h11111111, 1'b0, 1'b0, 32'h0,        1'b1);
        issue(2, "rg_lw_0ffc", 32'h0FFC, 4'b0000, 32'h0,        32'h500C, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1);
        issue(2, "rg_sw_103c", 32'h103C, 4'b1111, 32'h33333333, 32'h5010, 32'h0,        1'b0, 1'b1, 32'h33333333, 1'b1);
        issue(2, "rg_lw_103c", 32'h103C, 4'b0000, 32'h0,        32'h5014, 32'h33333333, 1'b0, 1'b0, 32'h0,        1'b1);

        // Reset while a store waits: it must vanish without trace or response
        issue(1, "w3_sw_10_drop", 32'h10, 4'b1111, 32'hDEADBEEF, 32'h6000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("midwait reset rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("midwait reset log_valid", 32'(wr_log_valid[1]), 32'd0);
        reset = 1'b0;
        wait_clear("midwait");
        issue(1, "w3_lw_10",  32'h10, 4'b0000, 32'h0,        32'h6004, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1);
        issue(0, "lw_8_clr",  32'h08, 4'b0000, 32'h0,        32'h6008, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
